clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock-enable generator; successor to the single fixed-rate display scan divider.
- Produces per-channel one-cycle tick strobes and 50%-duty toggle outputs from the system clock.
- Feeds seven-segment anode scan, LCD controller timing and button debounce sampling.
- Divisors reload at run time without glitches. All channels can be phase-aligned with one strobe.

Parameters:
- N_CH, 4, number of independent divider channels
- CNT_W, 24, counter/divisor width in bits
- CLK_FREQ_HZ, 50_000_000, system clock frequency; used only to derive the default divisors
- DEF_DIV, CLK_FREQ_HZ/1000, reset divisor for every channel (1 kHz tick at 50 MHz)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous, active-low reset
- en  in  N_CH  per-channel enable
- sync_clr  in  1  synchronous phase-align strobe for all channels
- div_wr  in  1  divisor write strobe
- div_sel  in  $clog2(N_CH)  channel addressed by div_wr
- div_val  in  CNT_W  new divisor; 0 is treated as 1
- tick  out  N_CH  one-cycle pulse per channel period
- clk_out  out  N_CH  toggles on each tick; period is 2*div cycles
- div_cur  out  N_CH*CNT_W  divisor currently active per channel, channel 0 in the LSBs

Behaviour:
- Reset (nrst low, asynchronous):
  - cnt = 0, tick = 0, clk_out = 0 for all channels.
  - Active and pending divisors = DEF_DIV; pend_valid = 0.
- Per channel, en = 1:
  - cnt increments every clk.
  - When cnt == div_act-1: cnt <= 0, tick = 1 for exactly that cycle, clk_out toggles at the same edge.
  - tick is registered, so the first tick after reset appears div_act cycles after reset release.
- en = 0:
  - cnt, clk_out and the divisor hold their values; tick = 0.
  - Raising en again resumes the count from the held cnt value (no restart).
- Effective divisor: div_eff = (div_val == 0) ? 1 : div_val. With div = 1, tick is high every cycle while en = 1 and clk_out toggles every cycle.
- Divisor write (div_wr = 1):
  - div_eff goes into the pending register of channel div_sel; pend_valid = 1.
  - A second write before the pending value is applied overwrites it (last write wins).
  - div_sel >= N_CH: write ignored.
- Divisor apply:
  - The pending value becomes active at the terminal count (the cycle tick fires); pend_valid is then cleared.
  - This keeps clk_out glitch-free: no shortened or stretched half-period mixes the old and new divisors.
  - If en = 0, the pending value waits until counting resumes and reaches terminal count.
- sync_clr = 1:
  - All cnt = 0 and all clk_out = 0 on the next edge; tick = 0 that cycle.
  - Pending divisors are applied immediately.
  - Takes priority over terminal count and over div_wr to the same channel; that write is lost.
- Simultaneous div_wr and terminal count on the same channel: the old pending value (if any) is applied, and the new write becomes pending.
- div_cur reflects the active divisor registers.
- Width rule: all compares are CNT_W bits wide; cnt never exceeds div_act-1, so there is no wrap-around.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W default
  - function div_from_hz(clk_hz, out_hz) returning the divisor
  - localparams for standard rates: SCAN_1KHZ, DEBOUNCE_100HZ, LCD_10KHZ
- Sub-module clk_div_ch:
  - One channel: counter, active/pending divisor, tick, clk_out.
  - Instantiated N_CH times in a generate loop.
  - The top level does only write decode, sync_clr fan-out and port packing.

Test Plan:
- Reset with DEF_DIV = 4, en = 1111: first tick on each channel 4 cycles after nrst rises, then every 4 cycles; clk_out period 8 cycles, 50% duty.
- Channel 1, div 5: write div_val = 3 at cnt = 1. Ticks continue at period 5 until the next terminal count, then period 3. clk_out never has a high or low phase shorter than 3 cycles.
- div_val = 0 to channel 2: behaves as div 1; tick is continuously high and clk_out toggles every cycle.
- Drop en[0] low for 7 cycles at cnt = 2 (div 4): no ticks and clk_out frozen. The first tick comes 2 cycles after en returns high.
- Channels running with div 3/4/5/6: assert sync_clr. All cnt and clk_out go to 0, and the subsequent first ticks occur at cycles 3/4/5/6 after the strobe.
- Assert nrst low mid-count with a write pending: all outputs 0 immediately (asynchronous), divisors return to DEF_DIV, and the pending write is discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
// Standard divisors assume the 50 MHz board clock.
package clk_div_pkg;

  localparam int DEF_CNT_W  = 24;
  localparam int SYS_CLK_HZ = 50_000_000;

  function automatic int div_from_hz(
    input int clk_hz,
    input int out_hz
  );
    if (out_hz <= 0 || clk_hz < out_hz) begin
      return 1;
    end
    return clk_hz / out_hz;
  endfunction

  localparam int SCAN_1KHZ      = div_from_hz(SYS_CLK_HZ, 1_000);
  localparam int DEBOUNCE_100HZ = div_from_hz(SYS_CLK_HZ, 100);
  localparam int LCD_10KHZ      = div_from_hz(SYS_CLK_HZ, 10_000);

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/pending divisor, tick and toggle.
// New divisors only take effect at terminal count or on a phase clear.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_val_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic [CNT_W-1:0] div_o
);

  localparam logic [CNT_W-1:0] RST_DIV =
    (DEF_DIV < 1) ? CNT_W'(1) : CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pv_q, pv_d;
  logic             tick_q, tick_d;
  logic             tgl_q, tgl_d;
  logic             term;
  logic [CNT_W-1:0] wr_eff;

  assign term   = (cnt_q == act_q - CNT_W'(1));
  assign wr_eff = (wr_val_i == '0) ? CNT_W'(1) : wr_val_i;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    tick_d = 1'b0;
    tgl_d  = tgl_q;
    if (clr_i) begin
      cnt_d = '0;
      tgl_d = 1'b0;
      if (pv_q) begin
        act_d = pend_q;
        pv_d  = 1'b0;
      end
    end else begin
      if (en_i) begin
        if (term) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          tgl_d  = ~tgl_q;
          if (pv_q) begin
            act_d = pend_q;
            pv_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // a write in the apply cycle becomes the next pending value
      if (wr_i) begin
        pend_d = wr_eff;
        pv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      pend_q <= RST_DIV;
      pv_q   <= 1'b0;
      tick_q <= 1'b0;
      tgl_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      tick_q <= tick_d;
      tgl_q  <= tgl_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = tgl_q;
  assign div_o     = act_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator.
// Top level decodes divisor writes and fans out the phase clear.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CLK_FREQ_HZ = SYS_CLK_HZ,
  parameter int DEF_DIV     = div_from_hz(CLK_FREQ_HZ, 1_000)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [N_CH-1:0]         en,
  input  logic                    sync_clr,
  input  logic                    div_wr,
  input  logic [$clog2(N_CH)-1:0] div_sel,
  input  logic [CNT_W-1:0]        div_val,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH*CNT_W-1:0]   div_cur
);

  localparam int SEL_W = $clog2(N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             wr_hit;
    logic [CNT_W-1:0] div_w;

    assign wr_hit = div_wr && (div_sel == SEL_W'(i));

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk),
      .nrst      (nrst),
      .en_i      (en[i]),
      .clr_i     (sync_clr),
      .wr_i      (wr_hit),
      .wr_val_i  (div_val),
      .tick_o    (tick[i]),
      .clk_out_o (clk_out[i]),
      .div_o     (div_w)
    );

    assign div_cur[i*CNT_W +: CNT_W] = div_w;
  end

endmodule
